// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter (shift-add-3) with START/BUSY/DONE
// handshake, optional two's-complement input, overflow saturation and blank mask.
module bin_to_bcd_seq #(
  parameter int BIN_W    = 10,
  parameter int DIGITS   = 4,
  parameter int SIGNED   = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcdout_o,
  output logic                  sign_o,
  output logic                  ovf_o,
  output logic [DIGITS-1:0]     blank_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADJ, S_SHIFT, S_FIN} state_t;

  state_t             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   mag_q;
  logic               neg_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               neg_d;
  logic [BIN_W-1:0]   mag_d;
  logic [BCD_W-1:0]   res_d;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit is blankable only if it and every more significant digit are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] b, input logic ovf);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (b[4*i +: 4] == 4'd0);
      m[i]       = zero_above & ~ovf & (BLANK_LZ != 0);
    end
    return m;
  endfunction

  // Negating in BIN_W bits keeps -2^(BIN_W-1) as an unsigned magnitude.
  assign neg_d = (SIGNED != 0) && bin_i[BIN_W-1];
  assign mag_d = neg_d ? (~bin_i + BIN_W'(1)) : bin_i;
  assign res_d = ovf_q ? {DIGITS{4'h9}} : bcd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      bcd_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      bcdout_o <= '0;
      sign_o   <= 1'b0;
      ovf_o    <= 1'b0;
      blank_o  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= S_ADJ;
          end
        end
        S_ADJ: begin
          bcd_q   <= add3(bcd_q);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          {bcd_q, mag_q} <= {bcd_q[BCD_W-2:0], mag_q, 1'b0};
          ovf_q          <= ovf_q | bcd_q[BCD_W-1];
          cnt_q          <= cnt_q + CNT_W'(1);
          state_q        <= (cnt_q == CNT_W'(BIN_W - 1)) ? S_FIN : S_ADJ;
        end
        S_FIN: begin
          bcdout_o <= res_d;
          sign_o   <= neg_q;
          ovf_o    <= ovf_q;
          blank_o  <= lz_mask(bcd_q, ovf_q);
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
